// File: rtl/change_pkg.sv
// change_pkg: shared types and constants for the change dispenser.
//   state_t        - dispenser FSM states
//   COIN0..COIN2   - coin indices (bit position on the one-hot coin bus)
//   coin_onehot_t  - 3-bit one-hot coin selection
//   coin_onehot()  - index to one-hot helper
package change_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned COIN0 = 0;
    localparam int unsigned COIN1 = 1;
    localparam int unsigned COIN2 = 2;

    typedef logic [2:0] coin_onehot_t;

    function automatic coin_onehot_t coin_onehot(input int unsigned k);
        coin_onehot_t oh;
        oh = '0;
        oh[k] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/coin_select.sv
// coin_select: combinational priority picker. Chooses the largest coin whose
// value fits in the remaining amount and whose stock is non-zero.
//   rem    in  AMT_W : amount still owed
//   avail  in  3     : bit k high when stock k > 0
//   sel    out 3     : one-hot chosen coin (all-zero when none)
//   found  out 1     : a candidate coin exists
module coin_select
    import change_pkg::*;
#(
    parameter int unsigned AMT_W = 8,
    parameter int unsigned VAL2  = 25,
    parameter int unsigned VAL1  = 10,
    parameter int unsigned VAL0  = 5
) (
    input  logic [AMT_W-1:0] rem,
    input  logic [2:0]       avail,
    output coin_onehot_t     sel,
    output logic             found
);

    localparam logic [AMT_W-1:0] V2 = AMT_W'(VAL2);
    localparam logic [AMT_W-1:0] V1 = AMT_W'(VAL1);
    localparam logic [AMT_W-1:0] V0 = AMT_W'(VAL0);

    always_comb begin
        sel   = '0;
        found = 1'b0;
        if (avail[COIN2] && (V2 <= rem)) begin
            sel   = coin_onehot(COIN2);
            found = 1'b1;
        end else if (avail[COIN1] && (V1 <= rem)) begin
            sel   = coin_onehot(COIN1);
            found = 1'b1;
        end else if (avail[COIN0] && (V0 <= rem)) begin
            sel   = coin_onehot(COIN0);
            found = 1'b1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: issues change one coin per handshake, largest first,
// tracking per-coin stock and reporting a shortfall when exact change fails.
//   clk, rst              : clock, synchronous active-high reset
//   start_valid/ready     : request handshake (ready only in IDLE)
//   amount                : change owed, sampled on start handshake
//   coin_valid/ready      : coin handshake towards the ejector
//   coin_sel              : one-hot coin, zero whenever coin_valid is low
//   done                  : one-cycle end-of-request pulse
//   short, remainder      : shortfall flag and undispensed amount, held until next start
//   refill_en, refill_cnt : per-coin stock reload strobes and value
//   stock_empty           : bit k high when stock k == 0
module change_dispenser
    import change_pkg::*;
#(
    parameter int unsigned AMT_W      = 8,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned VAL2       = 25,
    parameter int unsigned VAL1       = 10,
    parameter int unsigned VAL0       = 5,
    parameter int unsigned INIT_STOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [AMT_W-1:0] amount,
    output logic             coin_valid,
    input  logic             coin_ready,
    output logic [2:0]       coin_sel,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remainder,
    input  logic [2:0]       refill_en,
    input  logic [CNT_W-1:0] refill_cnt,
    output logic [2:0]       stock_empty
);

    if (!((VAL2 > VAL1) && (VAL1 > VAL0) && (VAL0 > 0) && (VAL2 < (2 ** AMT_W)))) begin : g_bad_values
        $error("change_dispenser: coin values must satisfy VAL2 > VAL1 > VAL0 > 0 and fit in AMT_W");
    end

    state_t                       state, state_nxt;
    logic [AMT_W-1:0]             rem;
    logic [2:0][CNT_W-1:0]        stock;
    coin_onehot_t                 sel_reg;
    coin_onehot_t                 pick;
    logic                         found;
    logic [AMT_W-1:0]             sel_val;
    logic                         coin_hs;

    always_comb begin
        for (int unsigned k = 0; k < 3; k++) begin
            stock_empty[k] = (stock[k] == '0);
        end
    end

    coin_select #(
        .AMT_W (AMT_W),
        .VAL2  (VAL2),
        .VAL1  (VAL1),
        .VAL0  (VAL0)
    ) u_select (
        .rem   (rem),
        .avail (~stock_empty),
        .sel   (pick),
        .found (found)
    );

    always_comb begin
        sel_val = '0;
        unique case (sel_reg)
            3'b100:  sel_val = AMT_W'(VAL2);
            3'b010:  sel_val = AMT_W'(VAL1);
            3'b001:  sel_val = AMT_W'(VAL0);
            default: sel_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        coin_valid  = 1'b0;
        done        = 1'b0;
        unique case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_nxt = CALC;
            end
            CALC: begin
                if ((rem != '0) && found) state_nxt = ISSUE;
                else                      state_nxt = DONE;
            end
            ISSUE: begin
                coin_valid = 1'b1;
                if (coin_ready) state_nxt = CALC;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign coin_hs  = coin_valid && coin_ready;
    assign coin_sel = sel_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem       <= '0;
            sel_reg   <= '0;
            short     <= 1'b0;
            remainder <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_valid) begin
                        rem       <= amount;
                        short     <= 1'b0;
                        remainder <= '0;
                    end
                end
                CALC: begin
                    if ((rem != '0) && found) begin
                        sel_reg <= pick;
                    end else begin
                        short     <= (rem != '0);
                        remainder <= rem;
                    end
                end
                ISSUE: begin
                    // Selection guarantees sel_val <= rem, so no underflow.
                    if (coin_ready) begin
                        rem     <= rem - sel_val;
                        sel_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Refill takes priority over a same-cycle decrement of the same counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < 3; k++) stock[k] <= CNT_W'(INIT_STOCK);
        end else begin
            for (int unsigned k = 0; k < 3; k++) begin
                if (refill_en[k])
                    stock[k] <= refill_cnt;
                else if (coin_hs && sel_reg[k] && (stock[k] != '0))
                    stock[k] <= stock[k] - CNT_W'(1);
            end
        end
    end

endmodule
